video_timing_pattern: RTL and testbench

//  Parametrised video timing generator with selectable test patterns.
//  It is the generalised successor to the fixed 640x480 generator: resolution, porches, sync polarity
//  and pattern set are all parameters, and the pattern can be switched at runtime.
//  It sits in the clk_pixel domain and drives vga2dvid: vga_r/g/b, vga_hsync, vga_vsync, vga_blank.
//  It also exports pixel coordinates and frame strobes for downstream overlay logic.

---
 rtl/video_timing_pattern_pkg.sv | 30 +++
 rtl/video_timing_pattern_if.sv | 32 +++
 rtl/video_timing_pattern_pattern_gen.sv | 62 ++++++
 rtl/video_timing_pattern.sv | 126 ++++++++++++
 tb/tb_video_timing_pattern.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pattern_pkg.sv
// Shared constants for the parametrised video timing / test pattern generator:
// pattern codes, colour-bar table and the default 640x480@60 timing set.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [2:0] PAT_SOLID    = 3'd0;
    localparam logic [2:0] PAT_BARS     = 3'd1;
    localparam logic [2:0] PAT_CHECKER  = 3'd2;
    localparam logic [2:0] PAT_GRADIENT = 3'd3;
    localparam logic [2:0] PAT_SCROLL   = 3'd4;

    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_BLUE  = 24'h0000FF;

    // Index 0 is the leftmost bar: W,Y,C,G,M,R,B,K.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/video_timing_pattern_if.sv
// Pixel-domain bundle between the timing/pattern generator and the DVI encoder / overlay logic.
// There is no handshake: every output is valid on every clk_pixel cycle and the sink never stalls.
interface video_timing_pattern_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int FRAME_W = 8
);
    logic [2:0]         pattern_sel;
    logic [23:0]        solid_rgb;
    logic [7:0]         vga_r;
    logic [7:0]         vga_g;
    logic [7:0]         vga_b;
    logic               vga_hsync;
    logic               vga_vsync;
    logic               vga_blank;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  pattern_sel, solid_rgb,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank,
               pix_x, pix_y, frame_start, frame_count
    );

    modport slave (
        output pattern_sel, solid_rgb,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank,
               pix_x, pix_y, frame_start, frame_count
    );
endinterface

// File: rtl/video_timing_pattern_pattern_gen.sv
// Registered test-pattern colour for one pixel; one clock of delay so it lines up with the
// registered sync/blank outputs of the top level.
module pattern_gen
    import video_timing_pkg::*;
#(
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int FRAME_W      = 8,
    parameter int H_ACTIVE     = 640,
    parameter int CHECKER_LOG2 = 5
) (
    input  logic               clk_pixel,
    input  logic               rst,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic               active,
    input  logic [2:0]         sel,
    input  logic [FRAME_W-1:0] frame_count,
    input  logic [23:0]        solid,
    output logic [23:0]        rgb
);
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [15:0] xe, ye, fe;
    logic [15:0] bar_q;
    logic [2:0]  bar_idx;
    logic        checker_on;
    logic [15:0] scroll_ofs;
    logic        scroll_on;
    logic [23:0] color;

    assign xe = 16'(x);
    assign ye = 16'(y);
    assign fe = 16'(frame_count);

    assign bar_q      = xe / 16'(BAR_W);
    assign bar_idx    = (bar_q > 16'd7) ? 3'd7 : bar_q[2:0];
    assign checker_on = |(((xe ^ ye) >> CHECKER_LOG2) & 16'd1);
    // Subtraction modulo 64 makes the bar wrap around the screen as frames advance.
    assign scroll_ofs = (xe - fe) & 16'h003F;
    assign scroll_on  = scroll_ofs < 16'd8;

    always_comb begin
        color = solid;
        case (sel)
            PAT_BARS:     color = BAR_RGB[bar_idx];
            PAT_CHECKER:  color = checker_on ? RGB_WHITE : RGB_BLACK;
            PAT_GRADIENT: color = {xe[7:0], ye[7:0], xe[7:0] ^ ye[7:0]};
            PAT_SCROLL:   color = scroll_on ? RGB_WHITE : RGB_BLUE;
            default:      color = solid;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            rgb <= RGB_BLACK;
        end else begin
            rgb <= active ? color : RGB_BLACK;
        end
    end

endmodule

// File: rtl/video_timing_pattern.sv
// Parametrised video timing generator: h/v counters, sync/blank decode, per-frame pattern latch
// and output registers, all aligned one clock after the counter state.
module video_timing_pattern
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter bit H_POL        = 1'b0,
    parameter bit V_POL        = 1'b0,
    parameter int CHECKER_LOG2 = 5,
    parameter int FRAME_W      = 8
) (
    input  logic clk_pixel,
    input  logic rst,
    video_timing_pattern_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [31:0]    HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0]    HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0]    VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0]    VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0]     hcount;
    logic [Y_W-1:0]     vcount;
    logic [2:0]         sel_q;
    logic [23:0]        solid_q;
    logic [FRAME_W-1:0] frame_count_q;
    logic [FRAME_W-1:0] fc_pix;
    logic [31:0]        hc32, vc32;
    logic               line_end, frame_end, frame_first;
    logic               active, hs_on, vs_on;
    logic [23:0]        rgb;

    logic               hsync_q, vsync_q, blank_q, frame_start_q;
    logic [X_W-1:0]     pix_x_q;
    logic [Y_W-1:0]     pix_y_q;

    assign hc32        = 32'(hcount);
    assign vc32        = 32'(vcount);
    assign line_end    = (hcount == H_LAST);
    assign frame_end   = line_end && (vcount == V_LAST);
    assign frame_first = (hcount == '0) && (vcount == '0);
    assign active      = (hc32 < 32'(H_ACTIVE)) && (vc32 < 32'(V_ACTIVE));
    assign hs_on       = (hc32 >= HS_START) && (hc32 < HS_END);
    assign vs_on       = (vc32 >= VS_START) && (vc32 < VS_END);
    // The pixel at (0,0) must already see the count that frame_count shows alongside it.
    assign fc_pix      = frame_first ? frame_count_q + 1'b1 : frame_count_q;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            hcount        <= '0;
            vcount        <= '0;
            sel_q         <= PAT_SOLID;
            solid_q       <= vid.solid_rgb;
            frame_count_q <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            if (line_end) begin
                hcount <= '0;
                vcount <= frame_end ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
            if (frame_end) begin
                sel_q   <= vid.pattern_sel;
                solid_q <= vid.solid_rgb;
            end
            if (frame_first) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
            hsync_q       <= hs_on ? H_POL : ~H_POL;
            vsync_q       <= vs_on ? V_POL : ~V_POL;
            blank_q       <= ~active;
            frame_start_q <= frame_first;
            pix_x_q       <= hcount;
            pix_y_q       <= vcount;
        end
    end

    pattern_gen #(
        .X_W          (X_W),
        .Y_W          (Y_W),
        .FRAME_W      (FRAME_W),
        .H_ACTIVE     (H_ACTIVE),
        .CHECKER_LOG2 (CHECKER_LOG2)
    ) u_pattern_gen (
        .clk_pixel   (clk_pixel),
        .rst         (rst),
        .x           (hcount),
        .y           (vcount),
        .active      (active),
        .sel         (sel_q),
        .frame_count (fc_pix),
        .solid       (solid_q),
        .rgb         (rgb)
    );

    assign vid.vga_r       = rgb[23:16];
    assign vid.vga_g       = rgb[15:8];
    assign vid.vga_b       = rgb[7:0];
    assign vid.vga_hsync   = hsync_q;
    assign vid.vga_vsync   = vsync_q;
    assign vid.vga_blank   = blank_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_pattern.sv
// Directed bench: default-timing line checks, then a small-timing instance for frame/pattern
// checks and an inverted-polarity, 2-bit frame counter instance.
module tb_video_timing_pattern;

    logic clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    logic rst_p = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    video_timing_pattern_if #(.X_W(10), .Y_W(10), .FRAME_W(8)) vid_d ();
    video_timing_pattern_if #(.X_W(7),  .Y_W(6),  .FRAME_W(8)) vid_s ();
    video_timing_pattern_if #(.X_W(7),  .Y_W(6),  .FRAME_W(2)) vid_p ();

    video_timing_pattern u_dut_d (
        .clk_pixel (clk_pixel),
        .rst       (rst_d),
        .vid       (vid_d)
    );

    video_timing_pattern #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) u_dut_s (
        .clk_pixel (clk_pixel),
        .rst       (rst_s),
        .vid       (vid_s)
    );

    video_timing_pattern #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .H_POL(1'b1), .V_POL(1'b1), .FRAME_W(2)
    ) u_dut_p (
        .clk_pixel (clk_pixel),
        .rst       (rst_p),
        .vid       (vid_p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_pixel);
    endtask

    function automatic logic [31:0] rgb_s();
        return 32'({vid_s.vga_r, vid_s.vga_g, vid_s.vga_b});
    endfunction

    task automatic wait_s_pix(input int x, input int y);
        int n = 0;
        while (!(int'(vid_s.pix_x) == x && int'(vid_s.pix_y) == y) && n < 8000) begin
            step();
            n++;
        end
        if (n >= 8000) chk("wait_s_pix_timeout", 32'(n), 0);
    endtask

    task automatic wait_s_frame();
        int n = 0;
        step();
        while (vid_s.frame_start !== 1'b1 && n < 8000) begin
            step();
            n++;
        end
        if (n >= 8000) chk("wait_s_frame_timeout", 32'(n), 0);
    endtask

    initial begin
        int hs_cnt, hs_first, bl_cnt, bl_bad, fs_cnt, vs_cnt, vs_first_y, vs_first_x, vs_last_y;
        int gap, idx, n;
        int fc_seen[5];
        int exp_fc[5] = '{1, 2, 3, 0, 1};

        vid_d.pattern_sel = 3'd0;
        vid_d.solid_rgb   = 24'hABCDEF;
        vid_s.pattern_sel = 3'd0;
        vid_s.solid_rgb   = 24'hABCDEF;
        vid_p.pattern_sel = 3'd0;
        vid_p.solid_rgb   = 24'h000000;

        // ---- reset idle values, both polarities ----
        repeat (4) step();
        chk("d_idle_flags_rgb", 32'({vid_d.vga_blank, vid_d.vga_hsync, vid_d.vga_vsync,
            vid_d.frame_start, vid_d.vga_r, vid_d.vga_g, vid_d.vga_b}), 'hE000000);
        chk("d_idle_pix_fc", 32'({vid_d.pix_x, vid_d.pix_y, vid_d.frame_count}), 0);
        chk("p_idle_flags_rgb", 32'({vid_p.vga_blank, vid_p.vga_hsync, vid_p.vga_vsync,
            vid_p.frame_start, vid_p.vga_r, vid_p.vga_g, vid_p.vga_b}), 'h8000000);

        // ---- default timing: first pulse and one full line ----
        rst_d = 1'b0;
        step();
        chk("d_first_frame_start", 32'(vid_d.frame_start), 1);
        chk("d_first_pix", 32'({vid_d.pix_x, vid_d.pix_y}), 0);
        chk("d_first_blank", 32'(vid_d.vga_blank), 0);
        chk("d_first_frame_count", 32'(vid_d.frame_count), 1);
        hs_cnt = 0; hs_first = -1; bl_cnt = 0; bl_bad = 0; fs_cnt = 0;
        for (int i = 0; i < 799; i++) begin
            step();
            if (!vid_d.vga_hsync) begin
                if (hs_cnt == 0) hs_first = int'(vid_d.pix_x);
                hs_cnt++;
            end
            if (vid_d.vga_blank) bl_cnt++;
            if (vid_d.vga_blank !== (int'(vid_d.pix_x) >= 640)) bl_bad++;
            if (vid_d.frame_start) fs_cnt++;
        end
        chk("d_hsync_width", 32'(hs_cnt), 96);
        chk("d_hsync_start_x", 32'(hs_first), 656);
        chk("d_blank_count", 32'(bl_cnt), 160);
        chk("d_blank_region", 32'(bl_bad), 0);
        chk("d_no_extra_frame_start", 32'(fs_cnt), 0);
        step();
        chk("d_line_wrap", 32'({vid_d.pix_x, vid_d.pix_y}), 32'({10'd0, 10'd1}));

        // ---- small timing: frame period and vsync window ----
        rst_s = 1'b0;
        step();
        chk("s_first_frame_start", 32'(vid_s.frame_start), 1);
        chk("s_first_frame_count", 32'(vid_s.frame_count), 1);
        gap = 0; vs_cnt = 0; vs_first_y = -1; vs_first_x = -1; vs_last_y = -1;
        do begin
            step();
            gap++;
            if (!vid_s.vga_vsync) begin
                if (vs_cnt == 0) begin
                    vs_first_y = int'(vid_s.pix_y);
                    vs_first_x = int'(vid_s.pix_x);
                end
                vs_last_y = int'(vid_s.pix_y);
                vs_cnt++;
            end
        end while (vid_s.frame_start !== 1'b1 && gap < 5000);
        chk("s_frame_period", 32'(gap), 3840);
        chk("s_vsync_cycles", 32'(vs_cnt), 160);
        chk("s_vsync_first_y", 32'(vs_first_y), 42);
        chk("s_vsync_first_x", 32'(vs_first_x), 0);
        chk("s_vsync_last_y", 32'(vs_last_y), 43);
        chk("s_second_pulse_pix", 32'({vid_s.pix_x, vid_s.pix_y}), 0);

        // ---- mid-frame pattern request is deferred to the next frame ----
        wait_s_pix(10, 20);
        vid_s.pattern_sel = 3'd1;
        wait_s_pix(30, 25);
        chk("s_solid_holds_midframe", rgb_s(), 'hABCDEF);
        wait_s_frame();
        chk("s_frame3_count", 32'(vid_s.frame_count), 3);
        chk("s_bar_x0_white", rgb_s(), 'hFFFFFF);
        wait_s_pix(8, 0);
        chk("s_bar_x8_yellow", rgb_s(), 'hFFFF00);
        wait_s_pix(20, 0);
        chk("s_bar_x20_cyan", rgb_s(), 'h00FFFF);
        wait_s_pix(40, 0);
        chk("s_bar_x40_red", rgb_s(), 'hFF0000);
        wait_s_pix(63, 0);
        chk("s_bar_x63_black", rgb_s(), 'h000000);
        wait_s_pix(70, 0);
        chk("s_hblank_rgb", 32'({vid_s.vga_blank, vid_s.vga_r, vid_s.vga_g, vid_s.vga_b}), 'h1000000);
        vid_s.pattern_sel = 3'd2;
        wait_s_pix(0, 40);
        chk("s_vblank_flag", 32'(vid_s.vga_blank), 1);

        // ---- checkerboard ----
        wait_s_frame();
        chk("s_chk_0_0_black", rgb_s(), 'h000000);
        wait_s_pix(32, 0);
        chk("s_chk_32_0_white", rgb_s(), 'hFFFFFF);
        wait_s_pix(0, 32);
        chk("s_chk_0_32_white", rgb_s(), 'hFFFFFF);
        wait_s_pix(32, 32);
        chk("s_chk_32_32_black", rgb_s(), 'h000000);
        vid_s.pattern_sel = 3'd3;

        // ---- gradient ----
        wait_s_frame();
        wait_s_pix(5, 3);
        chk("s_grad_5_3", rgb_s(), 'h050306);
        wait_s_pix(60, 39);
        chk("s_grad_60_39", rgb_s(), 'h3C271B);
        vid_s.pattern_sel = 3'd4;

        // ---- scrolling bar, frame_count = 6 -> white for x in 6..13 ----
        wait_s_frame();
        chk("s_frame6_count", 32'(vid_s.frame_count), 6);
        wait_s_pix(5, 1);
        chk("s_scroll_x5_blue", rgb_s(), 'h0000FF);
        wait_s_pix(6, 1);
        chk("s_scroll_x6_white", rgb_s(), 'hFFFFFF);
        wait_s_pix(13, 1);
        chk("s_scroll_x13_white", rgb_s(), 'hFFFFFF);
        wait_s_pix(14, 1);
        chk("s_scroll_x14_blue", rgb_s(), 'h0000FF);
        vid_s.pattern_sel = 3'd7;
        vid_s.solid_rgb   = 24'h123456;

        // ---- reserved code shows the solid colour ----
        wait_s_frame();
        wait_s_pix(10, 10);
        chk("s_reserved7_solid", rgb_s(), 'h123456);

        // ---- reset in the middle of a frame ----
        wait_s_pix(5, 30);
        rst_s = 1'b1;
        vid_s.pattern_sel = 3'd2;
        step();
        chk("s_midreset_flags_rgb", 32'({vid_s.vga_blank, vid_s.vga_hsync, vid_s.vga_vsync,
            vid_s.frame_start, vid_s.vga_r, vid_s.vga_g, vid_s.vga_b}), 'hE000000);
        chk("s_midreset_pix_fc", 32'({vid_s.pix_x, vid_s.pix_y, vid_s.frame_count}), 0);
        step();
        rst_s = 1'b0;
        step();
        chk("s_restart_pulse", 32'({vid_s.frame_start, vid_s.pix_x, vid_s.pix_y}), 32'({1'b1, 13'd0}));
        chk("s_restart_frame_count", 32'(vid_s.frame_count), 1);
        step();
        chk("s_restart_advance", 32'({vid_s.pix_x, vid_s.pix_y}), 32'({7'd1, 6'd0}));

        // ---- inverted polarity and 2-bit frame counter ----
        rst_p = 1'b0;
        step();
        fc_seen[0] = int'(vid_p.frame_count);
        idx = 0; n = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first_y = -1;
        while (idx < 4 && n < 20000) begin
            step();
            n++;
            if (idx == 0) begin
                if (vid_p.vga_hsync && vid_p.pix_y == '0) begin
                    if (hs_cnt == 0) hs_first = int'(vid_p.pix_x);
                    hs_cnt++;
                end
                if (vid_p.vga_vsync) begin
                    if (vs_cnt == 0) vs_first_y = int'(vid_p.pix_y);
                    vs_cnt++;
                end
            end
            if (vid_p.frame_start) begin
                idx++;
                fc_seen[idx] = int'(vid_p.frame_count);
            end
        end
        chk("p_frames_seen", 32'(idx), 4);
        chk("p_hsync_high_width", 32'(hs_cnt), 8);
        chk("p_hsync_start_x", 32'(hs_first), 68);
        chk("p_vsync_high_cycles", 32'(vs_cnt), 160);
        chk("p_vsync_first_y", 32'(vs_first_y), 42);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p_frame_count_seq%0d", i), 32'(fc_seen[i]), 32'(exp_fc[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
